// File: rtl/countdown_timer.sv
// countdown_timer
//   Round clock for the game. An internal prescaler derives a one-in-DIV
//   tick enable from i_clk (no derived clocks). The count is loaded, started,
//   paused and resumed by the game FSM. Registered tick and expiry pulses
//   are provided, plus a low-time warning and two BCD digits for the display.
//
// Ports
//   i_clk           system clock, rising edge
//   i_reset         synchronous reset, active low
//   i_load          abort and load i_load_value (state -> IDLE, prescaler -> 0)
//   i_load_value    value captured on i_load
//   i_start         level: start from IDLE / resume from PAUSED
//   i_pause         level: RUN -> PAUSED
//   o_count         remaining time
//   o_running       high in RUN
//   o_warn          RUN/PAUSED with 0 < count <= WARN_AT
//   o_expired       high in EXPIRED
//   o_expired_pulse one cycle on entry to EXPIRED
//   o_tick          one cycle per decrement
//   o_bcd_tens/ones BCD digits of min(count, 99)
module countdown_timer #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 1,
  parameter int WIDTH       = 8,
  parameter int START_VALUE = 20,
  parameter int WARN_AT     = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_start,
  input  logic             i_pause,
  output logic [WIDTH-1:0] o_count,
  output logic             o_running,
  output logic             o_warn,
  output logic             o_expired,
  output logic             o_expired_pulse,
  output logic             o_tick,
  output logic [3:0]       o_bcd_tens,
  output logic [3:0]       o_bcd_ones
);

  localparam int DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
  localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_RST   = WIDTH'(START_VALUE);
  localparam logic [31:0]      WARN_U    = 32'(WARN_AT);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("countdown_timer: CLK_HZ/TICK_HZ must be >= 2");
    end
    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
      $error("countdown_timer: WIDTH must be within 4..16");
    end
    if (START_VALUE < 0 || START_VALUE >= (1 << WIDTH)) begin : g_bad_start
      $error("countdown_timer: START_VALUE does not fit in WIDTH bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [PW-1:0]    r_presc, w_presc_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_pulse, w_pulse_nxt;
  logic             w_step;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_count <= CNT_RST;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
      r_tick  <= w_tick_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_pulse_nxt = 1'b0;
    w_step      = 1'b0;

    if (i_load) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = i_load_value;
      w_presc_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (r_count != '0) begin
              w_state_nxt = ST_RUN;
              w_presc_nxt = '0;
            end else begin
              w_state_nxt = ST_EXPIRED;
              w_pulse_nxt = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_pause) w_state_nxt = ST_PAUSED;
          else         w_step      = 1'b1;
        end
        ST_PAUSED: begin
          // The resume edge counts as a running cycle, so a pause of P
          // cycles shifts every later decrement by exactly P cycles.
          if (!i_pause && i_start) begin
            w_state_nxt = ST_RUN;
            w_step      = 1'b1;
          end
        end
        default: ; // EXPIRED: only load/reset leave
      endcase

      if (w_step) begin
        if (r_presc == PRESC_MAX) begin
          w_presc_nxt = '0;
          if (r_count != '0) begin
            w_tick_nxt  = 1'b1;
            w_count_nxt = r_count - WIDTH'(1);
            if (r_count == WIDTH'(1)) begin
              w_state_nxt = ST_EXPIRED;
              w_pulse_nxt = 1'b1;
            end
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
    end
  end

  // BCD of the saturated count; division by a constant stays combinational.
  logic [16:0] w_cnt_ext;
  logic [6:0]  w_sat;
  always_comb begin
    w_cnt_ext  = 17'(r_count);
    w_sat      = (w_cnt_ext > 17'd99) ? 7'd99 : w_cnt_ext[6:0];
    o_bcd_tens = 4'(w_sat / 7'd10);
    o_bcd_ones = 4'(w_sat % 7'd10);
  end

  assign o_count         = r_count;
  assign o_running       = (r_state == ST_RUN);
  assign o_expired       = (r_state == ST_EXPIRED);
  assign o_expired_pulse = r_pulse;
  assign o_tick          = r_tick;
  assign o_warn          = ((r_state == ST_RUN) || (r_state == ST_PAUSED)) &&
                           (r_count != '0) && (32'(r_count) <= WARN_U);

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Parametrised countdown timer for the game's round clock: a generalised successor to the fixed 20-second down-counter. It derives its own tick enable from the system clock with an internal prescaler; no derived clock is used. It adds a loadable start value, start/pause/resume control, a low-time warning flag, an expiry pulse and two-digit BCD outputs for the seven-segment driver. It sits between the game FSM, which issues the controls, and the score/display logic.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `TICK_HZ`, 1: countdown rate. `DIV = CLK_HZ/TICK_HZ`; DIV ≥ 2 is required, and anything else is an elaboration error.
- `WIDTH`, 8: count width. Must satisfy 4 ≤ WIDTH ≤ 16.
- `START_VALUE`, 20: count value after reset. Must be < 2^WIDTH.
- `WARN_AT`, 5: `warn` is high while running or paused with 0 < count ≤ WARN_AT.

Ports:
- `clk` in 1: single system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `load` in 1: when high, `count <= load_value`, state becomes IDLE and the prescaler clears.
- `load_value` in WIDTH: value captured on `load`.
- `start` in 1: level, sampled every cycle. Starts from IDLE, or resumes from PAUSED.
- `pause` in 1: level. In RUN, moves to PAUSED.
- `count` out WIDTH: current remaining time.
- `running` out 1: high in RUN.
- `warn` out 1: low-time flag.
- `expired` out 1: high in EXPIRED.
- `expired_pulse` out 1: one-cycle pulse on entry to EXPIRED.
- `tick` out 1: one-cycle pulse on each decrement.
- `bcd_tens`, `bcd_ones` out 4 each: BCD digits of `min(count, 99)`.

## Operation
- States are IDLE, RUN, PAUSED and EXPIRED. All state and register updates are registered.
- Priority per cycle: reset, then load, then pause, then start, then tick.
- `reset` low gives: state IDLE, `count = START_VALUE`, prescaler 0, and all flag and pulse outputs 0. The BCD outputs track the count.
- IDLE:
  - `start` with count > 0 goes to RUN with the prescaler cleared.
  - `start` with count = 0 goes directly to EXPIRED and fires `expired_pulse`.
- RUN:
  - The prescaler increments each cycle.
  - When the prescaler = DIV-1: the prescaler wraps to 0, `tick` pulses, and count decrements.
  - If the decrement takes count 1→0, the same edge enters EXPIRED and `expired_pulse` fires.
  - `pause` goes to PAUSED.
- PAUSED:
  - The prescaler and count hold, so the fractional period is preserved.
  - `start` with `pause` low returns to RUN. Counting continues from the held prescaler value.
- EXPIRED:
  - Count holds at 0. There is no wrap-around and no underflow.
  - Only `load` or `reset` leaves this state. `start` is ignored.
- `load` in any state aborts the timer. It clears the prescaler and suppresses any `tick` or `expired_pulse` in that cycle.
- `load` while `start` is high: load wins. The timer starts on a later cycle only if `start` is still high then.
- `pause` and `start` both high in RUN or PAUSED: the result is PAUSED.
- BCD conversion is combinational from the registered count. For count ≥ 99 the output is tens = 9, ones = 9.
- `warn` is combinational from state and count. It is 0 in IDLE and EXPIRED.

## Timing
- Start sampled at edge E: `running` = 1 after E. The first decrement happens at edge E+DIV, with `tick` high for the cycle following that edge.
- The steady tick period is exactly DIV cycles while in RUN.
- A pause of P cycles delays all subsequent decrements by exactly P cycles.
- `expired_pulse` is high for exactly one cycle, coincident with the first cycle where `expired` = 1 and count = 0.
- `load` takes effect on the edge where it is sampled, so `count` equals `load_value` on the next cycle.
- Reset asserted mid-run returns all outputs to reset values after that edge. No pending pulses remain.

## Test plan
Tests use CLK_HZ = 10 and TICK_HZ = 1 (DIV = 10), with WIDTH, START_VALUE and WARN_AT at their defaults.
- **Reset and run:** release reset, then hold `start` 1 cycle.
  - `count` steps 20→19 ten cycles after the start edge, then every 10 cycles.
  - `warn` rises when count = 5.
  - 200 cycles after start: count = 0, `expired` = 1, and `expired_pulse` is high exactly once.
- **Pause and resume:** pause for 37 cycles, 4 cycles into a tick period.
  - Count holds during the pause.
  - The next decrement comes 6 cycles after resume.
  - The total run is 237 cycles.
- **Load:** load `load_value` = 123 during RUN.
  - The next cycle shows count = 123, IDLE, and `bcd_tens`/`bcd_ones` = 9/9.
  - Start; at count = 42 the BCD outputs are 4/2.
- **Zero start:** load 0, then `start`.
  - `expired` and `expired_pulse` are high the next cycle.
  - No `tick` fires.
  - A later `start` has no effect.
- **Simultaneous events:**
  - `load` with `start` in the same cycle: the result is IDLE with the loaded count.
  - `pause` with `start` in RUN: the result is PAUSED.
  - `reset` low mid-run: the next cycle shows count = 20, IDLE, and all flags 0.
